// File: rtl/sram_arb_pkg.sv
// Shared types for the semiMIPS SRAM arbiter: FSM states, port ownership and
// the byte-offset width that defines word alignment.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int WORD_ALIGN_BITS = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; the remembered last grant only moves when
// the arbiter actually commits a grant from IDLE.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   advance,
  output logic   valid,
  output owner_t winner
);

  owner_t last_grant;

  // On a tie the port that was not served last wins
  always_comb begin
    valid  = i_req | d_req;
    winner = OWN_I;
    if (i_req && d_req) begin
      winner = (last_grant == OWN_D) ? OWN_I : OWN_D;
    end else if (d_req) begin
      winner = OWN_D;
    end
  end

  // Starting from D lets the fetch port win the first tie after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= OWN_D;
    end else if (advance && valid) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/sram.sv
// Single-port word SRAM: synchronous write, combinational read that floats
// whenever the array is not being read.
module sram #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic              clk,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [AWIDTH-1:0] address,
  input  logic [DWIDTH-1:0] din,
  output wire  [DWIDTH-1:0] dout
);

  localparam int WORD_BITS = 2;

  logic [DWIDTH-1:0]     mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_bits;

  assign idx         = address[WORD_BITS+DEPTH_LOG2-1:WORD_BITS];
  assign unused_bits = ^{address[AWIDTH-1:WORD_BITS+DEPTH_LOG2], address[WORD_BITS-1:0]};
  assign dout        = (cs && rd) ? mem[idx] : 'z;

  always_ff @(posedge clk) begin
    if (cs && wr) begin
      mem[idx] <= din;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single-port SRAM between instruction fetch and load/store with
// round-robin grants, registered SRAM pins and misalignment detection.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_ack,
  output logic [DWIDTH-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_ack,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_err,
  output logic              sram_cs,
  output logic              sram_rd,
  output logic              sram_wr,
  output logic [AWIDTH-1:0] sram_address,
  output logic [DWIDTH-1:0] sram_din,
  input  logic [DWIDTH-1:0] sram_dout
);

  state_t            state, next_state;
  owner_t            owner;
  owner_t            arb_winner;
  logic              arb_valid;
  logic              grant;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_misaligned;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .d_req   (d_req),
    .advance (grant),
    .valid   (arb_valid),
    .winner  (arb_winner)
  );

  // Fetches can never write, so the fetch side always presents a read
  always_comb begin
    sel_addr       = (arb_winner == OWN_D) ? d_addr : i_addr;
    sel_wdata      = d_wdata;
    sel_we         = (arb_winner == OWN_D) && d_we;
    sel_misaligned = |sel_addr[WORD_ALIGN_BITS-1:0];
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          grant      = 1'b1;
          next_state = sel_misaligned ? RESP : ACCESS;
        end
      end
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request fields are captured at grant, so later requester changes are ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner        <= OWN_I;
      sram_cs      <= 1'b0;
      sram_rd      <= 1'b0;
      sram_wr      <= 1'b0;
      sram_address <= '0;
      sram_din     <= '0;
      i_rdata      <= '0;
      i_err        <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= arb_winner;
            if (!sel_misaligned) begin
              sram_address <= sel_addr;
              sram_din     <= sel_wdata;
              sram_cs      <= 1'b1;
              sram_rd      <= !sel_we;
              sram_wr      <= sel_we;
              if (arb_winner == OWN_I) begin
                i_err <= 1'b0;
              end else begin
                d_err <= 1'b0;
              end
            end else if (arb_winner == OWN_I) begin
              i_err   <= 1'b1;
              i_rdata <= '0;
            end else begin
              d_err   <= 1'b1;
              d_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          sram_cs <= 1'b0;
          sram_rd <= 1'b0;
          sram_wr <= 1'b0;
          if (owner == OWN_I) begin
            i_rdata <= sram_rd ? sram_dout : '0;
          end else begin
            d_rdata <= sram_rd ? sram_dout : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_ack = (state == RESP) && (owner == OWN_I);
  assign d_ack = (state == RESP) && (owner == OWN_D);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and randomized bench for sram_arbiter backed by the real sram,
// checked against a transaction-level memory and round-robin model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        sram_cs, sram_rd, sram_wr;
  logic [31:0] sram_address, sram_din;
  wire  [31:0] sram_dout;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          nacks;
  logic        expp;

  logic [31:0] mem_model [64];
  bit          known     [64];
  bit          pend      [2];
  int          start     [2];
  logic [31:0] raddr     [2];
  logic [31:0] rdat      [2];
  bit          rwe       [2];
  logic        lastp;
  logic        ack_now;

  sram_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_ack        (i_ack),
    .i_rdata      (i_rdata),
    .i_err        (i_err),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .d_err        (d_err),
    .sram_cs      (sram_cs),
    .sram_rd      (sram_rd),
    .sram_wr      (sram_wr),
    .sram_address (sram_address),
    .sram_din     (sram_din),
    .sram_dout    (sram_dout)
  );

  sram #(.AWIDTH(32), .DWIDTH(32), .DEPTH_LOG2(8)) u_mem (
    .clk     (clk),
    .cs      (sram_cs),
    .rd      (sram_rd),
    .wr      (sram_wr),
    .address (sram_address),
    .din     (sram_din),
    .dout    (sram_dout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                               input logic [31:0] data);
    if (port == 1'b0) begin
      i_req  = 1'b1;
      i_addr = addr;
    end else begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = data;
    end
  endtask

  // Outputs are observed on the falling edge, away from the sampling edge
  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    checkOutput("rd_wr_exclusive", 64'(sram_rd & sram_wr), 64'd0);
    checkOutput("ack_exclusive", 64'(i_ack & d_ack), 64'd0);
  endtask

  task automatic checkAck(input int p);
    logic        mis;
    int          g;
    int          q;
    int          idx;
    logic        got_err;
    logic [31:0] got_rd;
    mis     = (raddr[p][1:0] != 2'b00);
    g       = cyc - (mis ? 1 : 2);
    q       = 1 - p;
    idx     = int'(raddr[p][7:2]);
    got_err = (p == 1) ? d_err : i_err;
    got_rd  = (p == 1) ? d_rdata : i_rdata;
    if (pend[q] && start[q] <= g) begin
      checkOutput("rr_winner", 64'(p), 64'(!lastp));
    end
    checkOutput("rand_err", 64'(got_err), 64'(mis));
    if (mis || rwe[p]) begin
      checkOutput("rand_rdata_zero", 64'(got_rd), 64'd0);
    end else if (known[idx]) begin
      checkOutput("rand_rdata", 64'(got_rd), 64'(mem_model[idx]));
    end
    if (!mis && rwe[p]) begin
      mem_model[idx] = rdat[p];
      known[idx]     = 1'b1;
    end
    lastp = (p == 1);
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) stepCycle();
    checkOutput("rst_i_ack", 64'(i_ack), 64'd0);
    checkOutput("rst_d_ack", 64'(d_ack), 64'd0);
    checkOutput("rst_errs", 64'({i_err, d_err}), 64'd0);
    checkOutput("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    checkOutput("rst_ctrl", 64'({sram_cs, sram_rd, sram_wr}), 64'd0);
    checkOutput("rst_addr_din", {sram_address, sram_din}, 64'd0);
    rst_n = 1'b1;

    // Store then fetch the same word
    applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    stepCycle();
    checkOutput("st_ctrl", 64'({sram_cs, sram_rd, sram_wr}), 64'b101);
    checkOutput("st_addr", 64'(sram_address), 64'h10);
    checkOutput("st_din", 64'(sram_din), 64'hDEADBEEF);
    checkOutput("st_early_ack", 64'(d_ack), 64'd0);
    stepCycle();
    checkOutput("st_ack", 64'({d_ack, d_err, sram_cs}), 64'b100);
    d_req = 1'b0;
    mem_model[4] = 32'hDEADBEEF; known[4] = 1'b1;
    stepCycle();
    checkOutput("st_ack_pulse", 64'(d_ack), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
    stepCycle();
    checkOutput("ld_ctrl", 64'({sram_cs, sram_rd, sram_wr}), 64'b110);
    stepCycle();
    checkOutput("ld_i_ack", 64'({i_ack, i_err}), 64'b10);
    checkOutput("ld_i_rdata", 64'(i_rdata), 64'hDEADBEEF);
    i_req = 1'b0;
    stepCycle();

    // Simultaneous requests after reset: fetch wins the first tie
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    stepCycle();
    checkOutput("tie_owner_addr", 64'({sram_rd, sram_address}), {31'd0, 1'b1, 32'h10});
    stepCycle();
    checkOutput("tie_first_i", 64'({i_ack, d_ack}), 64'b10);
    checkOutput("tie_i_rdata", 64'(i_rdata), 64'hDEADBEEF);
    i_req = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("tie_d_waiting", 64'(d_ack), 64'd0);
    stepCycle();
    checkOutput("tie_second_d", 64'({i_ack, d_ack}), 64'b01);
    checkOutput("tie_d_rdata", 64'(d_rdata), 64'hDEADBEEF);
    d_req = 1'b0;
    stepCycle();

    // Both ports held high: grants must alternate I, D, I, D ...
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    nacks = 0;
    expp  = 1'b0;
    for (int k = 0; k < 40 && nacks < 8; k++) begin
      stepCycle();
      if (i_ack || d_ack) begin
        checkOutput("alt_order", 64'(d_ack), 64'(expp));
        expp = !expp;
        nacks++;
      end
    end
    checkOutput("alt_count", 64'(nacks), 64'd8);
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (3) stepCycle();

    // Misaligned load completes in one cycle without touching the SRAM
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0);
    stepCycle();
    checkOutput("mis_ack_err", 64'({d_ack, d_err}), 64'b11);
    checkOutput("mis_rdata", 64'(d_rdata), 64'd0);
    checkOutput("mis_no_cs", 64'(sram_cs), 64'd0);
    d_req = 1'b0;
    stepCycle();
    checkOutput("mis_err_hold", 64'({d_ack, d_err}), 64'b01);

    // Reset lands on the ACCESS-closing edge of a store
    applyStimulus(1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    stepCycle();
    checkOutput("rsta_cs_wr", 64'({sram_cs, sram_wr}), 64'b11);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("rsta_acks", 64'({i_ack, d_ack}), 64'd0);
    checkOutput("rsta_ctrl", 64'({sram_cs, sram_rd, sram_wr, i_err, d_err}), 64'd0);
    checkOutput("rsta_addr_din", {sram_address, sram_din}, 64'd0);
    checkOutput("rsta_rdata", {i_rdata, d_rdata}, 64'd0);
    rst_n = 1'b1;
    d_req = 1'b0;
    mem_model[8] = 32'hCAFEF00D; known[8] = 1'b1;
    stepCycle();
    checkOutput("rsta_no_ack", 64'(d_ack), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("rsta_reload_ack", 64'(d_ack), 64'd1);
    checkOutput("rsta_reload_data", 64'(d_rdata), 64'hCAFEF00D);
    d_req = 1'b0;
    stepCycle();

    // Store data changed mid-access must not reach memory
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h1);
    stepCycle();
    d_wdata = 32'hFFFFFFFF;
    checkOutput("hold_din", 64'(sram_din), 64'h1);
    stepCycle();
    checkOutput("hold_ack", 64'(d_ack), 64'd1);
    d_req = 1'b0;
    mem_model[16] = 32'h1; known[16] = 1'b1;
    stepCycle();
    applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("hold_ack_i", 64'(i_ack), 64'd1);
    checkOutput("hold_mem", 64'(i_rdata), 64'h1);
    i_req = 1'b0;
    stepCycle();

    // Random traffic on both ports against the transaction model
    lastp = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      stepCycle();
      for (int p = 0; p < 2; p++) begin
        ack_now = (p == 1) ? d_ack : i_ack;
        if (pend[p] && ack_now) begin
          checkAck(p);
          pend[p] = 1'b0;
          if (p == 1) d_req = 1'b0; else i_req = 1'b0;
        end else if (pend[p] && (cyc - start[p] > 12)) begin
          checkOutput((p == 1) ? "d_timeout" : "i_timeout", 64'(cyc - start[p]), 64'd12);
          pend[p] = 1'b0;
          if (p == 1) d_req = 1'b0; else i_req = 1'b0;
        end else if (!pend[p]) begin
          checkOutput((p == 1) ? "d_ack_idle" : "i_ack_idle", 64'(ack_now), 64'd0);
          if (c < 960 && $urandom_range(0, 2) == 0) begin
            raddr[p] = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 5) == 0) raddr[p] = raddr[p] | 32'($urandom_range(1, 3));
            rwe[p]   = (p == 1) && ($urandom_range(0, 1) == 1);
            rdat[p]  = $urandom;
            applyStimulus(p == 1, rwe[p], raddr[p], rdat[p]);
            start[p] = cyc;
            pend[p]  = 1'b1;
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
